// File: rtl/mant_mul_seq14.sv
// mant_mul_seq14: 14x14 unsigned mantissa product built from four 7x7 partial products
// on one shared external multiplier, with valid/ready handshakes on both sides.
module mant_mul_seq14 #(
  parameter int MUL_LAT   = 0,
  parameter int ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] a,
  input  logic [13:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [27:0] product,
  output logic        busy,
  output logic [6:0]  mul_a,
  output logic [6:0]  mul_b,
  input  logic [13:0] mul_out
);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        ph_q, ph_d;
  logic [13:0] a_q, a_d, b_q, b_d;
  logic [27:0] acc_q, acc_d, pp;
  logic [6:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [4:0]  sh;
  logic        smp;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ph_d    = ph_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    smp     = (MUL_LAT == 0) || ph_q;
    sh      = (step_q[0] & step_q[1]) ? 5'd14 : (step_q[0] | step_q[1]) ? 5'd7 : 5'd0;
    pp      = {14'd0, mul_out} << sh;
    if (flush) begin
      state_d = IDLE;
      step_d  = 2'd0;
      ph_d    = 1'b0;
      acc_d   = 28'd0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        a_d     = a;
        b_d     = b;
        acc_d   = 28'd0;
        step_d  = 2'd0;
        ph_d    = 1'b0;
        state_d = (ZERO_SKIP != 0 && (a == 14'd0 || b == 14'd0)) ? DONE : STEP;
      end
    end else if (state_q == STEP) begin
      ph_d = !smp;
      if (smp) begin
        acc_d   = acc_q + pp;
        step_d  = step_q + 2'd1;
        state_d = (step_q == 2'd3) ? DONE : STEP;
      end
    end else if (out_ready) begin
      state_d = IDLE;
    end
    // operands for the step about to run are registered, so derive them from next-state values
    mul_a_d = (state_d == STEP) ? (step_d[1] ? a_d[13:7] : a_d[6:0]) : 7'd0;
    mul_b_d = (state_d == STEP) ? (step_d[0] ? b_d[13:7] : b_d[6:0]) : 7'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      ph_q    <= 1'b0;
      a_q     <= 14'd0;
      b_q     <= 14'd0;
      acc_q   <= 28'd0;
      mul_a_q <= 7'd0;
      mul_b_q <= 7'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign product   = out_valid ? acc_q : 28'd0;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
endmodule
